i2s_apb_stream_ctrl: RTL and testbench
======================================

// Module: i2s_apb_stream_ctrl
// PURPOSE
//  APB-side sequencer for the I2S transceiver core.
//  - On start: writes the control word, then loops polling the status register.
//  - Pushes samples from a valid/ready source into the Tx data register when Tx is not full.
//  - Pops the Rx data register into a valid/ready sink when Rx is not empty.
//  - On stop: writes the stop control word and returns idle. Sits between the audio datapath and the core's APB slave.
// PARAMETERS
//  OFFSET     0        base address of the I2S core; every paddr = OFFSET + reg address
//  CTRL_ADDR  32'h0    control register address
//  STAT_ADDR  32'h4    status register address; prdata[3:0] = {Tx_full,Tx_empty,Rx_full,Rx_empty}
//  TX_ADDR    32'h8    Tx data register address (write)
//  RX_ADDR    32'hC    Rx data register address (read)
//  STOP_WORD  32'h0    control word written on stop
// PORTS
//  pclk      in   1   clock; APB and all logic on rising edge
//  preset    in   1   asynchronous, active-low reset
//  start     in   1   1-cycle request: configure and run
//  stop      in   1   1-cycle request: halt
//  cfg_word  in   32  control word; sampled on the cycle start is accepted
//  busy      out  1   high in every state except IDLE
//  flags     out  4   last polled status bits [3:0]
//  tx_data   in   32  sample to transmit
//  tx_valid  in   1   tx_data valid; must hold with stable data until accepted
//  tx_ready  out  1   accept strobe; transfer occurs when tx_valid & tx_ready
//  rx_data   out  32  received sample (registered)
//  rx_valid  out  1   rx_data valid; held until rx_ready
//  rx_ready  in   1   sink accepts rx_data
//  paddr     out  32  APB address
//  pwdata    out  32  APB write data
//  pwrite    out  1   APB direction (1 = write)
//  penable   out  1   APB access phase
//  prdata    in   32  APB read data; sampled at end of the access cycle
// BEHAVIOUR
//  Reset (async):
//  - State -> IDLE; all outputs 0; priority bit = TX-first; stop_req = 0.
//  - Any in-flight APB transfer is abandoned.
//  APB transfers:
//  - Every transfer is SETUP (penable=0; paddr, pwrite, pwdata valid) followed by one ACCESS cycle (penable=1, same values).
//  - No wait states. paddr, pwdata and pwrite are registered.
//  States:
//  - IDLE:   start & !stop -> CFG_S. cfg_word is latched into pwdata with paddr = OFFSET + CTRL_ADDR.
//            start is ignored while busy; start & stop together in IDLE -> stay IDLE.
//  - CFG_S -> CFG_A -> POLL_S.
//  - POLL_S (read, OFFSET + STAT_ADDR) -> POLL_A. At end of POLL_A: flags <= prdata[3:0]; -> DECIDE.
//  - DECIDE (1 cycle, no APB activity):
//    - stop_req -> STOP_S.
//    - tx_elig = tx_valid & !flags[3]; rx_elig = !flags[0] & !rx_valid.
//    - Both eligible: serve the side given by the priority bit; the priority bit toggles after every granted service.
//    - One eligible: serve it.
//    - None eligible: -> POLL_S.
//  - TX_S: pwdata <= tx_data; tx_ready = 1 for exactly this cycle; -> TX_A -> POLL_S.
//  - RX_S (read, OFFSET + RX_ADDR) -> RX_A. At end of RX_A: rx_data <= prdata, rx_valid <= 1; -> POLL_S.
//  - STOP_S (write STOP_WORD to OFFSET + CTRL_ADDR) -> STOP_A -> IDLE; stop_req cleared.
//  Stop handling:
//  - stop seen in any busy state sets stop_req.
//  - The current APB transfer always completes; stop takes effect at the next DECIDE.
//  - stop in CFG_S/CFG_A -> the config write completes, then one poll, then STOP.
//  rx_valid:
//  - Cleared on rx_valid & rx_ready.
//  - At most one Rx sample is buffered; a set and a clear in the same cycle cannot occur (DECIDE requires rx_valid = 0).
//  Latency:
//  - start -> first penable = 2 cycles.
//  - One TX service loop = 5 cycles (POLL 2 + DECIDE 1 + TX 2); same for RX.
//  Full/empty:
//  - Tx_full blocks TX and Rx_empty blocks RX.
//  - Flags are stale for at most one loop; the core's FIFO full/empty guards cover that window.
// TESTING
//  1. Reset mid-TX_A: assert preset low -> penable = 0, busy = 0, tx_ready = 0, rx_valid = 0 on the same edge; state IDLE.
//  2. start, cfg_word = 32'h0000_0123 -> cycle 1 paddr = CTRL_ADDR, pwrite = 1, pwdata = 'h123, penable = 0; cycle 2 penable = 1; cycle 3 status read.
//  3. prdata = 4'b0101, tx_valid with tx_data = 'hA5A5 -> Tx register written with 'hA5A5, tx_ready pulses once; prdata = 4'b1001 -> no Tx write.
//  4. Rx not empty, rx_ready held 0 -> rx_data = Rx value, rx_valid = 1; no further Rx reads until rx_ready = 1.
//  5. Tx and Rx both eligible for 4 loops -> service order TX, RX, TX, RX.
//  6. stop during TX_S -> Tx write completes, poll, then STOP_WORD written to CTRL_ADDR, busy falls; start & stop together in IDLE -> no APB activity.

Source files
------------

// File: rtl/i2s_apb_stream_ctrl_if.sv
// APB master signals plus the Tx/Rx sample streams of the I2S stream sequencer.
// master = the sequencer, slave = the environment (APB core and audio datapath).
interface i2s_apb_stream_ctrl_if;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic [31:0] prdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output paddr, pwdata, pwrite, penable, tx_ready, rx_data, rx_valid,
    input  prdata, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  paddr, pwdata, pwrite, penable, tx_ready, rx_data, rx_valid,
    output prdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/i2s_apb_stream_ctrl.sv
// APB-side sequencer for the I2S transceiver core: configures the core, polls
// status, and moves samples between the core's data registers and the streams.
//
// state  | meaning
// IDLE   | waiting for start
// CFG_S  | control word write, setup
// CFG_A  | control word write, access
// POLL_S | status read, setup
// POLL_A | status read, access (flags captured)
// DECIDE | pick stop / TX / RX / re-poll
// TX_S   | Tx data write, setup (sample accepted)
// TX_A   | Tx data write, access
// RX_S   | Rx data read, setup
// RX_A   | Rx data read, access (sample captured)
// STOP_S | stop word write, setup
// STOP_A | stop word write, access
module i2s_apb_stream_ctrl #(
  parameter logic [31:0] OFFSET    = 32'h0,
  parameter logic [31:0] CTRL_ADDR = 32'h0,
  parameter logic [31:0] STAT_ADDR = 32'h4,
  parameter logic [31:0] TX_ADDR   = 32'h8,
  parameter logic [31:0] RX_ADDR   = 32'hC,
  parameter logic [31:0] STOP_WORD = 32'h0
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_word,
  output logic        busy,
  output logic [3:0]  flags,
  i2s_apb_stream_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, CFG_S, CFG_A, POLL_S, POLL_A, DECIDE,
    TX_S, TX_A, RX_S, RX_A, STOP_S, STOP_A
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] paddr_q, paddr_nxt;
  logic [31:0] pwdata_q, pwdata_nxt;
  logic        pwrite_q, pwrite_nxt;
  logic [31:0] rx_data_q;
  logic        rx_valid_q;
  logic [3:0]  flags_q;
  logic        stop_req;
  logic        prio_tx;
  logic        grant;
  logic        tx_elig, rx_elig;

  assign tx_elig = bus.tx_valid & ~flags_q[3];
  assign rx_elig = ~flags_q[0] & ~rx_valid_q;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state    <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      paddr_q  <= paddr_nxt;
      pwdata_q <= pwdata_nxt;
      pwrite_q <= pwrite_nxt;
    end
  end

  // Address/data/direction are loaded on entry to each SETUP state so they are
  // stable across both phases of the transfer.
  always_comb begin
    state_nxt  = state;
    paddr_nxt  = paddr_q;
    pwdata_nxt = pwdata_q;
    pwrite_nxt = pwrite_q;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt  = CFG_S;
          paddr_nxt  = OFFSET + CTRL_ADDR;
          pwdata_nxt = cfg_word;
          pwrite_nxt = 1'b1;
        end
      end
      CFG_S:  state_nxt = CFG_A;
      CFG_A, TX_A, RX_A: begin
        state_nxt  = POLL_S;
        paddr_nxt  = OFFSET + STAT_ADDR;
        pwrite_nxt = 1'b0;
      end
      POLL_S: state_nxt = POLL_A;
      POLL_A: state_nxt = DECIDE;
      DECIDE: begin
        if (stop_req) begin
          state_nxt  = STOP_S;
          paddr_nxt  = OFFSET + CTRL_ADDR;
          pwdata_nxt = STOP_WORD;
          pwrite_nxt = 1'b1;
        end else if (tx_elig && (!rx_elig || prio_tx)) begin
          state_nxt  = TX_S;
          paddr_nxt  = OFFSET + TX_ADDR;
          pwdata_nxt = bus.tx_data;
          pwrite_nxt = 1'b1;
          grant      = 1'b1;
        end else if (rx_elig) begin
          state_nxt  = RX_S;
          paddr_nxt  = OFFSET + RX_ADDR;
          pwrite_nxt = 1'b0;
          grant      = 1'b1;
        end else begin
          state_nxt  = POLL_S;
          paddr_nxt  = OFFSET + STAT_ADDR;
          pwrite_nxt = 1'b0;
        end
      end
      TX_S:   state_nxt = TX_A;
      RX_S:   state_nxt = RX_A;
      STOP_S: state_nxt = STOP_A;
      STOP_A: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      flags_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      stop_req   <= 1'b0;
      prio_tx    <= 1'b1;
    end else begin
      if (state == POLL_A)
        flags_q <= bus.prdata[3:0];
      if (state == RX_A) begin
        rx_data_q  <= bus.prdata;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (state == STOP_A)
        stop_req <= 1'b0;
      else if (stop && state != IDLE)
        stop_req <= 1'b1;
      if (grant)
        prio_tx <= ~prio_tx;
    end
  end

  assign busy         = (state != IDLE);
  assign flags        = flags_q;
  assign bus.paddr    = paddr_q;
  assign bus.pwdata   = pwdata_q;
  assign bus.pwrite   = pwrite_q;
  assign bus.penable  = (state == CFG_A) || (state == POLL_A) || (state == TX_A) ||
                        (state == RX_A)  || (state == STOP_A);
  assign bus.tx_ready = (state == TX_S);
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_i2s_apb_stream_ctrl.sv
// Scoreboard bench for i2s_apb_stream_ctrl: directed stimulus queues expected
// non-status APB transfers; a negedge monitor pops and compares them.
module tb_i2s_apb_stream_ctrl;
  localparam logic [31:0] CTRL = 32'h0;
  localparam logic [31:0] STAT = 32'h4;
  localparam logic [31:0] TXA  = 32'h8;
  localparam logic [31:0] RXA  = 32'hC;
  localparam logic [31:0] STOPW = 32'h0;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] cfg_word = '0;
  logic        busy;
  logic [3:0]  flags;
  logic [3:0]  stat_val = 4'b0101;
  logic [31:0] rx_val = '0;

  i2s_apb_stream_ctrl_if bus();

  i2s_apb_stream_ctrl dut (
    .pclk(pclk), .preset(preset), .start(start), .stop(stop),
    .cfg_word(cfg_word), .busy(busy), .flags(flags), .bus(bus)
  );

  always #5 pclk = ~pclk;

  // APB slave model: status and Rx data registers, no wait states
  always_comb begin
    bus.prdata = '0;
    if (bus.paddr == STAT)     bus.prdata = {28'd0, stat_val};
    else if (bus.paddr == RXA) bus.prdata = rx_val;
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    int          polls;
    string       name;
  } exp_t;

  exp_t expq[$];
  int n_vec = 0;
  int n_err = 0;
  int poll_cnt = 0;
  int tx_pulses = 0;
  logic [31:0] su_addr, su_wdata;
  logic        su_wr;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int p, input string n);
    exp_t e;
    e.addr = a; e.wr = w; e.data = d; e.polls = p; e.name = n;
    expq.push_back(e);
  endtask

  always @(negedge pclk) begin
    if (!preset) begin
      poll_cnt = 0;
    end else begin
      if (bus.tx_ready) tx_pulses++;
      if (bus.penable) begin
        chk("setup_hold", {bus.pwrite, bus.paddr, bus.pwdata}, {su_wr, su_addr, su_wdata});
        if (bus.paddr == STAT && !bus.pwrite) begin
          poll_cnt++;
        end else if (expq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_xfer: got addr %h wr %b data %h expected none",
                   bus.paddr, bus.pwrite, bus.pwdata);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk(e.name, {bus.pwrite, bus.paddr, bus.pwrite ? bus.pwdata : 32'h0},
                      {e.wr, e.addr, e.wr ? e.data : 32'h0});
          if (e.polls >= 0) chk({e.name, "_polls"}, 65'(poll_cnt), 65'(e.polls));
          poll_cnt = 0;
        end
      end
      su_addr = bus.paddr; su_wdata = bus.pwdata; su_wr = bus.pwrite;
    end
  end

  task automatic wait_tx(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      if (bus.tx_ready) begin ok = 1; return; end
    end
  endtask

  task automatic wait_rxv(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      if (bus.rx_valid) begin ok = 1; return; end
    end
  endtask

  task automatic pulse_start(input logic [31:0] w, input logic s);
    @(posedge pclk); #1;
    start = 1'b1; stop = s; cfg_word = w;
    @(posedge pclk); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    bit ok;
    int tx_cnt, rx_cnt, any_act;
    logic [31:0] td [3];
    td[0] = 32'h1000_0001; td[1] = 32'h2000_0002; td[2] = 32'h3000_0003;
    bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;

    // reset state
    #12;
    chk("rst_outputs", {bus.penable, busy, bus.tx_ready, bus.rx_valid, flags, bus.paddr},
                       {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0});
    @(posedge pclk); #1 preset = 1'b1;

    // start: control word write then status read
    push(CTRL, 1'b1, 32'h0000_0123, -1, "cfg_write");
    pulse_start(32'h0000_0123, 1'b0);
    @(negedge pclk);
    chk("cfg_setup", {busy, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
                     {1'b1, 1'b0, 1'b1, CTRL, 32'h0000_0123});
    @(negedge pclk);
    chk("cfg_access", {63'd0, bus.penable}, {63'd0, 1'b1});
    @(negedge pclk);
    chk("first_poll", {bus.penable, bus.pwrite, bus.paddr}, {1'b0, 1'b0, STAT});
    repeat (10) @(negedge pclk);
    chk("flags_0101", {61'd0, flags}, {61'd0, 4'b0101});

    // Tx sample accepted when not full
    push(TXA, 1'b1, 32'h0000_A5A5, -1, "tx_a5a5");
    @(posedge pclk); #1 bus.tx_data = 32'h0000_A5A5; bus.tx_valid = 1'b1;
    wait_tx(ok);
    chk("tx_accept_seen", {64'd0, ok}, {64'd0, 1'b1});
    @(posedge pclk); #1 bus.tx_valid = 1'b0;
    repeat (8) @(negedge pclk);
    chk("tx_pulse_once", 65'(tx_pulses), 65'd1);

    // Tx full blocks writes
    stat_val = 4'b1001;
    repeat (12) @(posedge pclk);
    #1 bus.tx_data = 32'h0000_5A5A; bus.tx_valid = 1'b1;
    repeat (20) @(negedge pclk);
    chk("tx_full_block", {60'(tx_pulses), flags}, {60'd1, 4'b1001});
    @(posedge pclk); #1 bus.tx_valid = 1'b0;

    // Rx not empty with sink stalled: one read, then hold
    push(RXA, 1'b0, 32'h0, -1, "rx_read1");
    rx_val = 32'hCAFE_0001;
    stat_val = 4'b0100;
    wait_rxv(ok);
    chk("rx_sample1", {ok, bus.rx_data}, {1'b1, 32'hCAFE_0001});
    repeat (20) @(negedge pclk);
    chk("rx_held", {64'd0, bus.rx_valid}, {64'd1});
    push(RXA, 1'b0, 32'h0, -1, "rx_read2");
    rx_val = 32'hCAFE_0002;
    @(posedge pclk); #1 bus.rx_ready = 1'b1;
    @(posedge pclk); #1 bus.rx_ready = 1'b0;
    wait_rxv(ok);
    chk("rx_sample2", {ok, bus.rx_data}, {1'b1, 32'hCAFE_0002});
    stat_val = 4'b0101;
    repeat (12) @(negedge pclk);

    // reset in the middle of a Tx access
    @(posedge pclk); #1 bus.tx_data = 32'h0000_1111; bus.tx_valid = 1'b1;
    wait_tx(ok);
    @(posedge pclk); #1;
    bus.tx_valid = 1'b0;
    chk("pre_reset_txa", {63'd0, ok, bus.penable}, {63'd0, 1'b1, 1'b1});
    chk("queue_empty_pre_reset", 65'(expq.size()), 65'd0);
    preset = 1'b0;
    #1;
    chk("reset_mid_txa", {61'd0, bus.penable, busy, bus.tx_ready, bus.rx_valid}, 65'd0);
    repeat (2) @(posedge pclk);
    #3 preset = 1'b1;

    // both sides eligible: TX, RX, TX, RX, then TX only once Rx empties
    push(CTRL, 1'b1, 32'h0000_0077, -1, "cfg2_write");
    pulse_start(32'h0000_0077, 1'b0);
    repeat (6) @(posedge pclk);
    push(TXA, 1'b1, td[0], -1, "rr_tx0");
    push(RXA, 1'b0, 32'h0, -1, "rr_rx0");
    push(TXA, 1'b1, td[1], -1, "rr_tx1");
    push(RXA, 1'b0, 32'h0, -1, "rr_rx1");
    push(TXA, 1'b1, td[2], -1, "rr_tx2");
    #1;
    rx_val = 32'h0000_D00D;
    bus.rx_ready = 1'b1;
    bus.tx_data = td[0]; bus.tx_valid = 1'b1;
    stat_val = 4'b0100;
    tx_cnt = 0; rx_cnt = 0;
    for (int i = 0; i < 300 && tx_cnt < 3; i++) begin
      @(negedge pclk);
      if (bus.tx_ready) begin
        tx_cnt++;
        @(posedge pclk); #1;
        if (tx_cnt < 3) bus.tx_data = td[tx_cnt];
        else bus.tx_valid = 1'b0;
      end else if (bus.rx_valid) begin
        rx_cnt++;
        if (rx_cnt == 2) stat_val = 4'b0101;
      end
    end
    chk("rr_counts", {33'd0, 16'(tx_cnt), 16'(rx_cnt)}, {33'd0, 16'd3, 16'd2});
    bus.rx_ready = 1'b0;
    repeat (10) @(negedge pclk);

    // stop during TX_S: write completes, one poll, stop word, idle
    push(TXA, 1'b1, 32'h0000_BEEF, -1, "stop_tx");
    push(CTRL, 1'b1, STOPW, 1, "stop_write");
    @(posedge pclk); #1 bus.tx_data = 32'h0000_BEEF; bus.tx_valid = 1'b1;
    wait_tx(ok);
    stop = 1'b1;
    @(posedge pclk); #1 stop = 1'b0; bus.tx_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge pclk);
      if (!busy) begin ok = 1; break; end
    end
    chk("busy_fall", {64'd0, ok}, {64'd1});
    chk("queue_drained", 65'(expq.size()), 65'd0);

    // start together with stop in IDLE is ignored
    pulse_start(32'h0000_0999, 1'b1);
    any_act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      if (busy || bus.penable) any_act++;
    end
    chk("start_stop_idle", 65'(any_act), 65'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
